// File: rtl/marker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : marker_pkg
// Description : Shared FSM state encoding and accumulator sizing for the
//               marker frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package marker_pkg;

    typedef enum logic [2:0] {
        ROW_ACTIVE = 3'd0,
        ROW_COMMIT = 3'd1,
        FRAME_EVAL = 3'd2,
        DIV_X      = 3'd3,
        DIV_Y      = 3'd4,
        CLEAR      = 3'd5
    } state_t;

    // Accumulator width large enough for a full frame of coordinate sums
    function automatic int acc_w_calc(input int width, input int height);
        return $clog2(width * height) + 1;
    endfunction

    localparam int ACC_W = acc_w_calc(1024, 768);

endpackage
`default_nettype wire

// File: rtl/marker_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : marker_frame_ctrl_if
// Description : Raster position, detector handshake and fused marker outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface marker_frame_ctrl_if #(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int MAX_WIDTH     = 100
);
    localparam int c_HCNT_W = $clog2(SCREEN_WIDTH) + 1;
    localparam int c_VCNT_W = $clog2(SCREEN_HEIGHT) + 1;
    localparam int c_WID_W  = $clog2(MAX_WIDTH) + 1;

    logic [c_HCNT_W-1:0] hcount_in;
    logic [c_VCNT_W-1:0] vcount_in;
    logic                det_rst_out;
    logic                det_done_in;
    logic [c_HCNT_W-1:0] det_coord_in;
    logic [c_WID_W-1:0]  det_width_in;
    logic [10:0]         det_prob_in;
    logic [c_HCNT_W-1:0] marker_x_out;
    logic [c_VCNT_W-1:0] marker_y_out;
    logic [c_WID_W-1:0]  marker_width_out;
    logic                marker_found_out;
    logic                marker_valid_out;

    modport slave (
        input  hcount_in, vcount_in, det_done_in, det_coord_in,
               det_width_in, det_prob_in,
        output det_rst_out, marker_x_out, marker_y_out, marker_width_out,
               marker_found_out, marker_valid_out
    );

    modport master (
        output hcount_in, vcount_in, det_done_in, det_coord_in,
               det_width_in, det_prob_in,
        input  det_rst_out, marker_x_out, marker_y_out, marker_width_out,
               marker_found_out, marker_valid_out
    );

endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring unsigned divider, one quotient bit per cycle.
//               done/quotient are valid during the final iteration cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 21
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic                  done,
    output logic [WIDTH-1:0]      quotient
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;

    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_unused;

    // Remainder never exceeds the divisor, so its top bit is always zero
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_unused   = w_rem_next[WIDTH];

    assign done     = r_busy && (r_cnt == c_CNT_W'(1));
    assign quotient = w_quo_next;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= c_CNT_W'(WIDTH);
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvs  <= divisor;
        end else if (r_busy) begin
            r_rem <= w_rem_next[WIDTH-1:0];
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/marker_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : marker_frame_ctrl
// Description : Sequences the per-row stripe detector, picks the best hit per
//               row and fuses clustered rows into one marker per frame.
//               Define MARKER_HOLD_EN to keep the last valid position on a
//               failing frame.
// Revision    : 1.0 - initial release
// ============================================================================
module marker_frame_ctrl
    import marker_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int MAX_WIDTH     = 100,
    parameter int PROB_THRES    = 40,
    parameter int X_TOL         = 16,
    parameter int MIN_ROWS      = 4
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    marker_frame_ctrl_if.slave bus
);
    localparam int c_HCNT_W = $clog2(SCREEN_WIDTH) + 1;
    localparam int c_VCNT_W = $clog2(SCREEN_HEIGHT) + 1;
    localparam int c_WID_W  = $clog2(MAX_WIDTH) + 1;
    localparam int c_HITS_W = $clog2(SCREEN_HEIGHT) + 1;
    localparam int c_ACC_W  = acc_w_calc(SCREEN_WIDTH, SCREEN_HEIGHT);

    state_t r_state;
    state_t w_next;

    logic                r_cand_valid;
    logic [c_HCNT_W-1:0] r_cand_coord;
    logic [c_WID_W-1:0]  r_cand_width;
    logic [10:0]         r_cand_prob;
    logic [c_VCNT_W-1:0] r_row_v;

    logic [c_ACC_W-1:0]  r_sum_x;
    logic [c_ACC_W-1:0]  r_sum_y;
    logic [c_HITS_W-1:0] r_hits;
    logic [c_HCNT_W-1:0] r_last_x;
    logic [c_WID_W-1:0]  r_wmax;
    logic                r_armed;

    logic                r_det_rst;
    logic [c_HCNT_W-1:0] r_qx;
    logic [c_HCNT_W-1:0] r_marker_x;
    logic [c_VCNT_W-1:0] r_marker_y;
    logic [c_WID_W-1:0]  r_marker_w;
    logic                r_found;
    logic                r_valid;

    logic                w_row_start;
    logic                w_row_end;
    logic                w_active_row;
    logic                w_cand_hit;
    logic [c_HCNT_W-1:0] w_dist;
    logic                w_accept;
    logic                w_enough;
    logic                w_div_start;
    logic                w_div_done;
    logic [c_ACC_W-1:0]  w_div_dividend;
    logic [c_ACC_W-1:0]  w_div_divisor;
    logic [c_ACC_W-1:0]  w_div_quo;
    logic                w_unused;

    assign w_row_start  = (bus.hcount_in == '0);
    assign w_row_end    = (bus.hcount_in == c_HCNT_W'(SCREEN_WIDTH - 1));
    assign w_active_row = (bus.vcount_in < c_VCNT_W'(SCREEN_HEIGHT));

    // Strictly-lower probability replaces the stored hit, so ties keep the first
    assign w_cand_hit = bus.det_done_in && !w_row_start && (r_state == ROW_ACTIVE)
                     && (bus.det_prob_in <= 11'(PROB_THRES))
                     && (!r_cand_valid || (bus.det_prob_in < r_cand_prob));

    assign w_dist   = (r_cand_coord >= r_last_x) ? (r_cand_coord - r_last_x)
                                                 : (r_last_x - r_cand_coord);
    assign w_accept = r_cand_valid && ((r_hits == '0) || (w_dist < c_HCNT_W'(X_TOL)));
    assign w_enough = (r_hits >= c_HITS_W'(MIN_ROWS));

    assign w_div_dividend = (r_state == DIV_X) ? r_sum_y : r_sum_x;
    assign w_div_divisor  = c_ACC_W'(r_hits);
    assign w_unused       = ^w_div_quo;

    seq_divider #(
        .WIDTH (c_ACC_W)
    ) u_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start    (w_div_start),
        .dividend (w_div_dividend),
        .divisor  (w_div_divisor),
        .done     (w_div_done),
        .quotient (w_div_quo)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ROW_ACTIVE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        case (r_state)
            ROW_ACTIVE: begin
                if (w_row_end && w_active_row) begin
                    w_next = ROW_COMMIT;
                end
            end
            ROW_COMMIT: begin
                // A frame entered mid-way (after reset) is discarded unevaluated
                if (r_row_v == c_VCNT_W'(SCREEN_HEIGHT - 1)) begin
                    w_next = r_armed ? FRAME_EVAL : CLEAR;
                end else begin
                    w_next = ROW_ACTIVE;
                end
            end
            FRAME_EVAL: begin
                if (w_enough) begin
                    w_div_start = 1'b1;
                    w_next      = DIV_X;
                end else begin
                    w_next = CLEAR;
                end
            end
            DIV_X: begin
                if (w_div_done) begin
                    w_div_start = 1'b1;
                    w_next      = DIV_Y;
                end
            end
            DIV_Y: begin
                if (w_div_done) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                w_next = ROW_ACTIVE;
            end
            default: begin
                w_next = ROW_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_det_rst <= 1'b1;
        end else begin
            r_det_rst <= w_row_start || !w_active_row || (r_state != ROW_ACTIVE);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cand_valid <= 1'b0;
            r_cand_coord <= '0;
            r_cand_width <= '0;
            r_cand_prob  <= '0;
            r_row_v      <= '0;
        end else begin
            if (w_row_start) begin
                r_cand_valid <= 1'b0;
            end else if (w_cand_hit) begin
                r_cand_valid <= 1'b1;
                r_cand_coord <= bus.det_coord_in;
                r_cand_width <= bus.det_width_in;
                r_cand_prob  <= bus.det_prob_in;
            end
            // Row number is captured at row end so commit is immune to vcount advancing
            if ((r_state == ROW_ACTIVE) && w_row_end) begin
                r_row_v <= bus.vcount_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_hits   <= '0;
            r_last_x <= '0;
            r_wmax   <= '0;
            r_armed  <= 1'b0;
        end else begin
            if ((r_state == ROW_ACTIVE) && w_row_start && (bus.vcount_in == '0)) begin
                r_armed <= 1'b1;
            end
            if ((r_state == ROW_COMMIT) && w_accept) begin
                r_sum_x  <= r_sum_x + c_ACC_W'(r_cand_coord);
                r_sum_y  <= r_sum_y + c_ACC_W'(r_row_v);
                r_hits   <= r_hits + c_HITS_W'(1);
                r_last_x <= r_cand_coord;
                if (r_cand_width > r_wmax) begin
                    r_wmax <= r_cand_width;
                end
            end
            if (r_state == CLEAR) begin
                r_sum_x  <= '0;
                r_sum_y  <= '0;
                r_hits   <= '0;
                r_last_x <= '0;
                r_wmax   <= '0;
                r_armed  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_qx       <= '0;
            r_marker_x <= '0;
            r_marker_y <= '0;
            r_marker_w <= '0;
            r_found    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state == FRAME_EVAL) && !w_enough) begin
                r_found <= 1'b0;
                r_valid <= 1'b1;
`ifndef MARKER_HOLD_EN
                r_marker_x <= '0;
                r_marker_y <= '0;
                r_marker_w <= '0;
`endif
            end
            if ((r_state == DIV_X) && w_div_done) begin
                r_qx <= w_div_quo[c_HCNT_W-1:0];
            end
            if ((r_state == DIV_Y) && w_div_done) begin
                r_marker_x <= r_qx;
                r_marker_y <= w_div_quo[c_VCNT_W-1:0];
                r_marker_w <= r_wmax;
                r_found    <= 1'b1;
                r_valid    <= 1'b1;
            end
        end
    end

    assign bus.det_rst_out      = r_det_rst;
    assign bus.marker_x_out     = r_marker_x;
    assign bus.marker_y_out     = r_marker_y;
    assign bus.marker_width_out = r_marker_w;
    assign bus.marker_found_out = r_found;
    assign bus.marker_valid_out = r_valid;

endmodule
`default_nettype wire

// File: doc/marker_frame_ctrl.md
Name: marker_frame_ctrl

Overview:
- Sequences the per-row stripe-flip detector across a video frame.
- Issues the detector's row reset at every row start and during vertical blanking.
- Selects the best detector hit per row (lowest not-target probability) and fuses accepted rows into one marker position per frame.
- Outputs feed the overlay/tracking logic downstream of marker detection.

Parameters:
- SCREEN_WIDTH, 1024, active pixels per row.
- SCREEN_HEIGHT, 768, active rows per frame.
- MAX_WIDTH, 100, max centre width from detector (sets width port size).
- PROB_THRES, 40, max det_prob_in accepted as a candidate.
- X_TOL, 16, max |coord - last accepted coord| for a row to join the frame cluster.
- MIN_ROWS, 4, min accepted rows for a valid frame result.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  reset, asynchronous, active-high
- hcount_in  input  $clog2(SCREEN_WIDTH)+1  current pixel column
- vcount_in  input  $clog2(SCREEN_HEIGHT)+1  current row
- det_rst_out  output  1  row reset to detector
- det_done_in  input  1  detector target-complete pulse
- det_coord_in  input  $clog2(SCREEN_WIDTH)+1  detector centre column
- det_width_in  input  $clog2(MAX_WIDTH)+1  detector centre width
- det_prob_in  input  11  detector not-target score
- marker_x_out  output  $clog2(SCREEN_WIDTH)+1  fused column
- marker_y_out  output  $clog2(SCREEN_HEIGHT)+1  fused row
- marker_width_out  output  $clog2(MAX_WIDTH)+1  max centre width among accepted rows
- marker_found_out  output  1  level: last completed frame produced a valid marker
- marker_valid_out  output  1  one-cycle pulse when outputs update

Behaviour:
- Reset (async): all outputs 0, det_rst_out=1, FSM=ROW_ACTIVE, all accumulators 0.
- det_rst_out is registered, 1-cycle latency. High when hcount_in==0, or when vcount_in>=SCREEN_HEIGHT, or when FSM!=ROW_ACTIVE.
- ROW_ACTIVE, per-row candidate capture:
  - A det_done_in pulse with det_prob_in<=PROB_THRES is a candidate.
  - It is stored if the row has no candidate yet, or det_prob_in < stored prob. A tie keeps the earlier candidate.
  - Row store is cleared at hcount_in==0.
  - det_done_in coincident with hcount_in==0 is ignored.
- hcount_in==SCREEN_WIDTH-1 in an active row moves the FSM to ROW_COMMIT for 1 cycle.
- ROW_COMMIT, candidate acceptance:
  - The candidate is accepted if hits==0, or |cand_coord - last_x| < X_TOL.
  - On accept: sum_x += coord; sum_y += vcount; hits++; last_x = coord; wmax = max(wmax, width).
  - Rejected rows change nothing.
  - Next state is ROW_ACTIVE, or FRAME_EVAL if vcount_in==SCREEN_HEIGHT-1.
- FRAME_EVAL:
  - If hits>=MIN_ROWS: start divider on sum_x/hits and go to DIV_X.
  - Else: marker_found_out<=0, marker_valid_out pulse, go to CLEAR.
- DIV_X, then DIV_Y: shared sequential divider, ACC_W cycles each. ACC_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)+1.
- When DIV_Y finishes:
  - Quotients are truncated and loaded into marker_x_out and marker_y_out.
  - marker_width_out<=wmax, marker_found_out<=1, marker_valid_out pulses for 1 cycle.
  - Go to CLEAR.
- CLEAR (1 cycle): zero sum_x, sum_y, hits, wmax, last_x; go to ROW_ACTIVE.
  - Total eval latency is 2*ACC_W+3 cycles. It must complete within vertical blanking.
  - Frame start is not re-checked.
- Accumulator widths: sum_x and sum_y are ACC_W bits, hits is $clog2(SCREEN_HEIGHT)+1 bits. No overflow is possible by construction.
- Mid-frame rst_in: discards partial accumulation. No marker_valid_out until a full frame completes.

Optional Feature:
- MARKER_HOLD_EN defined: a failing frame (hits<MIN_ROWS) leaves marker_x_out, marker_y_out and marker_width_out holding the last valid values. marker_found_out still drops to 0.
- Not defined: a failing frame zeroes those three outputs.

Decomposition:
- Package marker_pkg: FSM state enum (ROW_ACTIVE, ROW_COMMIT, FRAME_EVAL, DIV_X, DIV_Y, CLEAR) and the ACC_W helper constant.
- Sub-module seq_divider: restoring, 1 quotient bit per cycle.
  - Ports: start, dividend, divisor, done, quotient.
  - Parameterised width.
  - Reused for the X and Y divisions.

Test Plan:
- Reset asserted mid-row 100 -> all outputs 0, det_rst_out=1. After release, no marker_valid_out before the next full frame.
- Rows 300..309 each give one done: coord=500, prob=10, width=20 -> marker_x_out=500, marker_y_out=304, marker_width_out=20, found=1, one valid pulse.
- Row with two dones, (coord 200, prob 30) then (coord 600, prob 5) -> row candidate coord 600. Tie with prob 5 at coord 700 -> 600 kept.
- Rows 10..14 coord=400 plus row 15 coord=800 -> row 15 rejected, hits=5, marker_x_out=400, marker_y_out=12.
- Only 3 qualifying rows (MIN_ROWS=4) -> found=0, valid pulse. Outputs zeroed, or held at the previous frame's values when MARKER_HOLD_EN is defined.
- det_prob_in=41 on every done -> no candidates. det_rst_out high at every hcount_in==0 and throughout vcount_in>=768.
